// File: rtl/sv32_page_walker.sv
`default_nettype none
// ============================================================================
// Module   : sv32_page_walker
// Purpose  : Shared Sv32 hardware page-table walker. Arbitrates TLB-miss
//            requests (fixed priority, lowest index wins), performs the
//            two-level walk over a single-outstanding PTE read port and
//            broadcasts a one-cycle result pulse.
// Ports    : clk, rst (async, active-high)
//            IN_req_valid/rootPPN/addr  - per-requester miss requests
//            OUT_busy, OUT_rqID          - walk in progress and its owner
//            OUT_mem_*, IN_mem_*         - PTE read request/response port
//            OUT_res_*                   - translation result pulse
// Revision : 1.0 - initial release
// ============================================================================
module sv32_page_walker #(
  parameter int NUM_RQ  = 3,
  parameter int RQ_ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RQ-1:0]    IN_req_valid,
  input  logic [NUM_RQ*20-1:0] IN_req_rootPPN,
  input  logic [NUM_RQ*32-1:0] IN_req_addr,
  output logic                 OUT_busy,
  output logic [RQ_ID_W-1:0]   OUT_rqID,
  output logic                 OUT_mem_valid,
  output logic [31:0]          OUT_mem_addr,
  input  logic                 IN_mem_ready,
  input  logic                 IN_mem_rvalid,
  input  logic [31:0]          IN_mem_rdata,
  input  logic                 IN_mem_err,
  output logic                 OUT_res_valid,
  output logic [RQ_ID_W-1:0]   OUT_res_rqID,
  output logic [19:0]          OUT_res_vpn,
  output logic [19:0]          OUT_res_ppn,
  output logic [2:0]           OUT_res_rwx,
  output logic                 OUT_res_user,
  output logic                 OUT_res_global,
  output logic                 OUT_res_isSuper,
  output logic                 OUT_res_pageFault,
  output logic                 OUT_res_accessFault
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_L1_REQ  = 3'd1,
    S_L1_WAIT = 3'd2,
    S_L0_REQ  = 3'd3,
    S_L0_WAIT = 3'd4,
    S_RESULT  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [RQ_ID_W-1:0] r_id;
  logic [19:0]        r_root;
  logic [19:0]        r_vpn;
  logic [19:0]        r_l0_base;
  logic [19:0]        r_res_ppn;
  logic [2:0]         r_res_rwx;
  logic               r_res_user;
  logic               r_res_global;
  logic               r_res_super;
  logic               r_res_pf;
  logic               r_res_af;

  // Fixed-priority arbiter: scanning downward lets the lowest index win.
  logic               w_any;
  logic [RQ_ID_W-1:0] w_win_id;
  logic [19:0]        w_win_root;
  logic [19:0]        w_win_vpn;

  always_comb begin
    w_any      = 1'b0;
    w_win_id   = '0;
    w_win_root = '0;
    w_win_vpn  = '0;
    for (int i = NUM_RQ - 1; i >= 0; i--) begin
      if (IN_req_valid[i]) begin
        w_any      = 1'b1;
        w_win_id   = RQ_ID_W'(i);
        w_win_root = IN_req_rootPPN[i*20 +: 20];
        w_win_vpn  = IN_req_addr[i*32+12 +: 20];
      end
    end
  end

  // PTE field decode
  logic w_v, w_r, w_w, w_x, w_a, w_d, w_leaf;
  logic w_at_l1, w_pte_take;
  logic w_acc_flt, w_inv, w_svade, w_misal, w_go_l0, w_page_flt;

  assign w_v    = IN_mem_rdata[0];
  assign w_r    = IN_mem_rdata[1];
  assign w_w    = IN_mem_rdata[2];
  assign w_x    = IN_mem_rdata[3];
  assign w_a    = IN_mem_rdata[6];
  assign w_d    = IN_mem_rdata[7];
  assign w_leaf = w_r | w_x;

  assign w_at_l1    = (r_state == S_L1_WAIT);
  assign w_pte_take = IN_mem_rvalid & ((r_state == S_L1_WAIT) | (r_state == S_L0_WAIT));

  // PPN bits above 32-bit physical space count as an access fault.
  assign w_acc_flt  = IN_mem_err | (IN_mem_rdata[31:30] != 2'b00);
  assign w_inv      = ~w_v | (~w_r & w_w);
  assign w_svade    = ~w_a | (w_w & ~w_d);
  assign w_misal    = (IN_mem_rdata[19:10] != 10'd0);
  assign w_go_l0    = ~w_acc_flt & ~w_inv & ~w_leaf & w_at_l1;
  // Only meaningful once access fault and descent have been ruled out;
  // a non-leaf reaching here is necessarily at level 0.
  assign w_page_flt = w_inv | ~w_leaf | w_svade | (w_at_l1 & w_misal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    OUT_mem_valid = 1'b0;
    OUT_mem_addr  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_state_nxt = S_L1_REQ;
      end
      S_L1_REQ: begin
        OUT_mem_valid = 1'b1;
        OUT_mem_addr  = {r_root, r_vpn[19:10], 2'b00};
        if (IN_mem_ready) w_state_nxt = S_L1_WAIT;
      end
      S_L1_WAIT: begin
        if (IN_mem_rvalid) w_state_nxt = w_go_l0 ? S_L0_REQ : S_RESULT;
      end
      S_L0_REQ: begin
        OUT_mem_valid = 1'b1;
        OUT_mem_addr  = {r_l0_base, r_vpn[9:0], 2'b00};
        if (IN_mem_ready) w_state_nxt = S_L0_WAIT;
      end
      S_L0_WAIT: begin
        if (IN_mem_rvalid) w_state_nxt = S_RESULT;
      end
      S_RESULT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id         <= '0;
      r_root       <= '0;
      r_vpn        <= '0;
      r_l0_base    <= '0;
      r_res_ppn    <= '0;
      r_res_rwx    <= '0;
      r_res_user   <= 1'b0;
      r_res_global <= 1'b0;
      r_res_super  <= 1'b0;
      r_res_pf     <= 1'b0;
      r_res_af     <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_any) begin
        r_id        <= w_win_id;
        r_root      <= w_win_root;
        r_vpn       <= w_win_vpn;
        r_res_pf    <= 1'b0;
        r_res_af    <= 1'b0;
        r_res_super <= 1'b0;
      end
      if (w_pte_take) begin
        if (w_acc_flt) begin
          r_res_af <= 1'b1;
        end else if (w_go_l0) begin
          r_l0_base <= IN_mem_rdata[29:10];
        end else if (w_page_flt) begin
          r_res_pf <= 1'b1;
        end else begin
          // Superpage: low PPN half comes from the VA's VPN0.
          r_res_ppn    <= w_at_l1 ? {IN_mem_rdata[29:20], r_vpn[9:0]} : IN_mem_rdata[29:10];
          r_res_rwx    <= {w_r, w_w, w_x};
          r_res_user   <= IN_mem_rdata[4];
          r_res_global <= IN_mem_rdata[5];
          r_res_super  <= w_at_l1;
        end
      end
    end
  end

  assign OUT_busy            = (r_state != S_IDLE);
  assign OUT_rqID            = r_id;
  assign OUT_res_valid       = (r_state == S_RESULT);
  assign OUT_res_rqID        = r_id;
  assign OUT_res_vpn         = r_vpn;
  assign OUT_res_ppn         = r_res_ppn;
  assign OUT_res_rwx         = r_res_rwx;
  assign OUT_res_user        = r_res_user;
  assign OUT_res_global      = r_res_global;
  assign OUT_res_isSuper     = r_res_super;
  assign OUT_res_pageFault   = r_res_pf;
  assign OUT_res_accessFault = r_res_af;

endmodule
`default_nettype wire
